// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle X/Y/Z register + ULA control sequencer
module alu_op_sequencer #(
    parameter int SHAMT_W = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [2:0]         instr,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               opnd_valid,
    output logic               opnd_req,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [3:0]         current_state,
    output logic [3:0]         tx,
    output logic [3:0]         ty,
    output logic [3:0]         tz,
    output logic [3:0]         tula
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CLRALL  = 4'd1,
        S_FETCH_A = 4'd2,
        S_MOVE_A  = 4'd3,
        S_FETCH_B = 4'd4,
        S_SHIFT   = 4'd5,
        S_EXEC    = 4'd6,
        S_DONE    = 4'd7
    } state_t;

    localparam logic [3:0] R_CLEAR  = 4'd0;
    localparam logic [3:0] R_LOAD   = 4'd1;
    localparam logic [3:0] R_HOLD   = 4'd2;
    localparam logic [3:0] R_SHIFTR = 4'd3;

    localparam logic [3:0] U_ADD   = 4'd0;
    localparam logic [3:0] U_SUB   = 4'd1;
    localparam logic [3:0] U_AND   = 4'd2;
    localparam logic [3:0] U_OR    = 4'd3;
    localparam logic [3:0] U_PASSY = 4'd4;

    localparam logic [2:0] OP_CLR = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;
    localparam logic [2:0] OP_RSV = 3'd7;

    state_t             state;
    logic [2:0]         op_q;
    logic [SHAMT_W-1:0] cnt;
    logic               err_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            op_q  <= 3'd0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q <= instr;
                        cnt  <= shamt;
                        if (instr == OP_CLR) begin
                            state <= S_CLRALL;
                        end else if (instr == OP_RSV) begin
                            state <= S_DONE;
                            err_q <= 1'b1;
                        end else begin
                            state <= S_FETCH_A;
                        end
                    end
                end
                S_CLRALL: state <= S_DONE;
                S_FETCH_A: begin
                    if (opnd_valid) state <= S_MOVE_A;
                end
                S_MOVE_A: begin
                    case (op_q)
                        OP_ADD, OP_SUB, OP_AND, OP_OR: state <= S_FETCH_B;
                        OP_SHR: state <= (cnt != '0) ? S_SHIFT : S_EXEC;
                        default: state <= S_EXEC;
                    endcase
                end
                S_FETCH_B: begin
                    if (opnd_valid) state <= S_EXEC;
                end
                S_SHIFT: begin
                    // Leaving on cnt==1 makes the shift phase last exactly shamt cycles.
                    cnt <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) state <= S_EXEC;
                end
                S_EXEC: state <= S_DONE;
                S_DONE: begin
                    err_q <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        tx       = R_HOLD;
        ty       = R_HOLD;
        tz       = R_HOLD;
        tula     = U_ADD;
        opnd_req = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            S_CLRALL: begin
                tx = R_CLEAR;
                ty = R_CLEAR;
                tz = R_CLEAR;
            end
            S_FETCH_A, S_FETCH_B: begin
                // X loads only in the cycle the operand bus actually holds data.
                opnd_req = 1'b1;
                tx       = opnd_valid ? R_LOAD : R_HOLD;
            end
            S_MOVE_A: ty = R_LOAD;
            S_SHIFT:  ty = R_SHIFTR;
            S_EXEC: begin
                tz = R_LOAD;
                case (op_q)
                    OP_ADD:  tula = U_ADD;
                    OP_SUB:  tula = U_SUB;
                    OP_AND:  tula = U_AND;
                    OP_OR:   tula = U_OR;
                    default: tula = U_PASSY;
                endcase
            end
            S_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

    assign busy          = (state != S_IDLE);
    assign current_state = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

    localparam int SW = 3;
    localparam logic [3:0] C = 4'd0, L = 4'd1, H = 4'd2, S = 4'd3;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    instr = 3'd0;
    logic [SW-1:0] shamt = '0;
    logic          opnd_valid = 1'b0;
    logic          opnd_req, busy, done, err;
    logic [3:0]    current_state, tx, ty, tz, tula;

    alu_op_sequencer #(.SHAMT_W(SW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .instr(instr),
        .shamt(shamt), .opnd_valid(opnd_valid), .opnd_req(opnd_req),
        .busy(busy), .done(done), .err(err), .current_state(current_state),
        .tx(tx), .ty(ty), .tz(tz), .tula(tula)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        fixed;
        logic        vld;
        logic [19:0] o;
    } step_t;

    step_t q[$];

    function automatic logic [19:0] ov(input logic b, input logic r, input logic d,
                                       input logic e, input logic [3:0] x,
                                       input logic [3:0] y, input logic [3:0] z,
                                       input logic [3:0] u);
        return {b, r, d, e, x, y, z, u};
    endfunction

    wire  [19:0] obs = {busy, opnd_req, done, err, tx, ty, tz, tula};
    logic [19:0] idle_o;

    // Expected per-cycle outputs after start, built from the instruction's phases.
    function automatic void build(input int op, input int k, input int da, input int db);
        q.delete();
        if (op == 0) begin
            q.push_back('{1'b0, 1'b0, ov(1, 0, 0, 0, C, C, C, 4'd0)});
        end else if (op == 7) begin
            q.push_back('{1'b0, 1'b0, ov(1, 0, 1, 1, H, H, H, 4'd0)});
            return;
        end else begin
            for (int i = 0; i < da; i++) q.push_back('{1'b1, 1'b0, ov(1, 1, 0, 0, H, H, H, 4'd0)});
            q.push_back('{1'b1, 1'b1, ov(1, 1, 0, 0, L, H, H, 4'd0)});
            q.push_back('{1'b0, 1'b0, ov(1, 0, 0, 0, H, L, H, 4'd0)});
            if (op >= 1 && op <= 4) begin
                for (int i = 0; i < db; i++) q.push_back('{1'b1, 1'b0, ov(1, 1, 0, 0, H, H, H, 4'd0)});
                q.push_back('{1'b1, 1'b1, ov(1, 1, 0, 0, L, H, H, 4'd0)});
            end
            if (op == 5)
                for (int i = 0; i < k; i++) q.push_back('{1'b0, 1'b0, ov(1, 0, 0, 0, H, S, H, 4'd0)});
            q.push_back('{1'b0, 1'b0, ov(1, 0, 0, 0, H, H, L,
                                         (op >= 1 && op <= 4) ? 4'(op - 1) : 4'd4)});
        end
        q.push_back('{1'b0, 1'b0, ov(1, 0, 1, 0, H, H, H, 4'd0)});
    endfunction

    task automatic run_instr(input int op, input int k, input int da, input int db,
                             input bit hold, input string name);
        build(op, k, da, db);
        @(posedge clock); #1;
        start = 1'b1; instr = 3'(op); shamt = SW'(k); opnd_valid = 1'($urandom);
        @(negedge clock);
        n_tests++;
        if (obs !== idle_o || current_state !== 4'd0) begin
            n_fail++;
            $display("FAIL %s idle: got %h st %0d expected %h st 0", name, obs, current_state, idle_o);
        end
        for (int i = 0; i < q.size(); i++) begin
            @(posedge clock); #1;
            start = hold ? 1'b1 : 1'($urandom);
            instr = 3'($urandom);
            shamt = SW'($urandom);
            opnd_valid = q[i].fixed ? q[i].vld : 1'($urandom);
            @(negedge clock);
            n_tests++;
            if (obs !== q[i].o) begin
                n_fail++;
                $display("FAIL %s cyc%0d: got %h expected %h", name, i + 1, obs, q[i].o);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (obs !== idle_o || current_state !== 4'd0) begin
            n_fail++;
            $display("FAIL reset: got %h st %0d expected %h st 0", obs, current_state, idle_o);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset_mid_fetch_b();
        @(posedge clock); #1;
        start = 1'b1; instr = 3'd1; shamt = '0; opnd_valid = 1'b0;
        @(posedge clock); #1; start = 1'b0; opnd_valid = 1'b1;
        @(posedge clock); #1; opnd_valid = 1'b1;
        @(posedge clock); #1; opnd_valid = 1'b0;
        @(negedge clock);
        n_tests++;
        if (opnd_req !== 1'b1 || current_state !== 4'd4) begin
            n_fail++;
            $display("FAIL pre_reset: got req %b st %0d expected req 1 st 4", opnd_req, current_state);
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (obs !== idle_o || current_state !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h st %0d expected %h st 0", obs, current_state, idle_o);
        end
        opnd_valid = 1'b1;
        @(negedge clock);
        n_tests++;
        if (obs !== idle_o || done !== 1'b0) begin
            n_fail++;
            $display("FAIL held_reset: got %h expected %h", obs, idle_o);
        end
        reset_n = 1'b1;
        run_instr(1, 0, 0, 0, 1'b0, "add_after_reset");
    endtask

    task automatic test_directed();
        run_instr(1, 0, 0, 0, 1'b0, "add");
        run_instr(2, 0, 3, 0, 1'b0, "sub_wait3");
        run_instr(5, 5, 0, 0, 1'b0, "shr5");
        run_instr(5, 0, 0, 0, 1'b0, "shr0");
        run_instr(5, 7, 1, 0, 1'b0, "shr7");
        run_instr(0, 0, 0, 0, 1'b0, "clr");
        run_instr(7, 0, 0, 0, 1'b0, "rsv");
        run_instr(3, 0, 0, 2, 1'b0, "and_waitb");
        run_instr(4, 0, 1, 1, 1'b0, "or");
    endtask

    task automatic test_back_to_back();
        int dones;
        dones = 0;
        for (int i = 0; i < 4; i++) run_instr(6, 0, 0, 0, 1'b1, "mov_held");
        // Free-run with start held: one MOV every 5 cycles.
        @(posedge clock); #1;
        start = 1'b1; instr = 3'd6; opnd_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (done === 1'b1) dones++;
        end
        start = 1'b0;
        n_tests++;
        if (dones !== 4) begin
            n_fail++;
            $display("FAIL mov_stream: got %0d dones expected 4", dones);
        end
        repeat (6) @(posedge clock);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int op, k, da, db;
            op = $urandom_range(0, 7);
            k  = $urandom_range(0, 7);
            da = $urandom_range(0, 3);
            db = $urandom_range(0, 3);
            run_instr(op, k, da, db, 1'($urandom), "rand");
        end
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    initial begin
        idle_o = ov(0, 0, 0, 0, H, H, H, 4'd0);
        test_reset();
        test_directed();
        test_reset_mid_fetch_b();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
